// File: rtl/scmi_mbox_doorbell_master.sv
// AXI-Lite master for the SCMI shared-memory mailbox: writes the message, rings the doorbell,
// waits for the completion pulse, reads the response word back and returns it with a status.

package scmi_mbox_doorbell_master_pkg;

  typedef struct packed {
    logic [63:0] addr;
    logic [2:0]  prot;
  } axi_lite_ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } axi_lite_w_t;

  typedef struct packed {
    logic [1:0] resp;
  } axi_lite_b_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } axi_lite_r_t;

  typedef struct packed {
    axi_lite_ax_t aw;
    logic         aw_valid;
    axi_lite_w_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_lite_ax_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    axi_lite_b_t b;
    logic        b_valid;
    logic        ar_ready;
    axi_lite_r_t r;
    logic        r_valid;
  } axi_lite_resp_t;

endpackage

module scmi_mbox_doorbell_master
  import scmi_mbox_doorbell_master_pkg::*;
#(
  parameter int unsigned                AXI_ADDR_WIDTH  = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0]  MBOX_BASE       = '0,
  parameter logic [AXI_ADDR_WIDTH-1:0]  MSG_OFFSET      = 'h20,
  parameter logic [AXI_ADDR_WIDTH-1:0]  DOORBELL_OFFSET = 'h24,
  parameter int unsigned                TIMEOUT_CYCLES  = 1024
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic [31:0]    req_msg_i,
  output logic           rsp_valid_o,
  input  logic           rsp_ready_i,
  output logic [31:0]    rsp_data_o,
  output logic [1:0]     rsp_err_o,
  input  logic           completion_irq_i,
  output axi_lite_req_t  axi_lite_mbox_req_o,
  input  axi_lite_resp_t axi_lite_mbox_rsp_i
);

  localparam logic [63:0] MSG_ADDR = 64'(MBOX_BASE + MSG_OFFSET);
  localparam logic [63:0] DB_ADDR  = 64'(MBOX_BASE + DOORBELL_OFFSET);
  localparam int unsigned TW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_BUS     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    WR_MSG,
    WR_DB,
    WAIT_CMPL,
    RD_RSP,
    RESP
  } state_t;

  state_t        state_reg, state_next;
  logic          aw_valid_reg, aw_valid_next;
  logic          w_valid_reg, w_valid_next;
  logic          b_ready_reg, b_ready_next;
  logic          ar_valid_reg, ar_valid_next;
  logic          r_ready_reg, r_ready_next;
  logic [63:0]   aw_addr_reg, aw_addr_next;
  logic [31:0]   w_data_reg, w_data_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          rsp_valid_reg, rsp_valid_next;
  logic [31:0]   rsp_data_reg, rsp_data_next;
  logic [1:0]    rsp_err_reg, rsp_err_next;

  logic aw_hs, w_hs, ar_hs;

  assign aw_hs = aw_valid_reg & axi_lite_mbox_rsp_i.aw_ready;
  assign w_hs  = w_valid_reg & axi_lite_mbox_rsp_i.w_ready;
  assign ar_hs = ar_valid_reg & axi_lite_mbox_rsp_i.ar_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      aw_valid_reg  <= 1'b0;
      w_valid_reg   <= 1'b0;
      b_ready_reg   <= 1'b0;
      ar_valid_reg  <= 1'b0;
      r_ready_reg   <= 1'b0;
      aw_addr_reg   <= '0;
      w_data_reg    <= '0;
      timer_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= ERR_OK;
    end else begin
      state_reg     <= state_next;
      aw_valid_reg  <= aw_valid_next;
      w_valid_reg   <= w_valid_next;
      b_ready_reg   <= b_ready_next;
      ar_valid_reg  <= ar_valid_next;
      r_ready_reg   <= r_ready_next;
      aw_addr_reg   <= aw_addr_next;
      w_data_reg    <= w_data_next;
      timer_reg     <= timer_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    aw_valid_next  = aw_valid_reg;
    w_valid_next   = w_valid_reg;
    b_ready_next   = b_ready_reg;
    ar_valid_next  = ar_valid_reg;
    r_ready_next   = r_ready_reg;
    aw_addr_next   = aw_addr_reg;
    w_data_next    = w_data_reg;
    timer_next     = timer_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_err_next   = rsp_err_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid_i) begin
          state_next    = WR_MSG;
          aw_valid_next = 1'b1;
          w_valid_next  = 1'b1;
          aw_addr_next  = MSG_ADDR;
          w_data_next   = req_msg_i;
          rsp_err_next  = ERR_OK;
        end
      end

      WR_MSG, WR_DB: begin
        if (aw_hs) aw_valid_next = 1'b0;
        if (w_hs)  w_valid_next  = 1'b0;
        if (!b_ready_reg) begin
          // B is only accepted once both address and data have been taken.
          b_ready_next = (!aw_valid_reg || aw_hs) && (!w_valid_reg || w_hs);
        end else if (axi_lite_mbox_rsp_i.b_valid) begin
          b_ready_next = 1'b0;
          if (axi_lite_mbox_rsp_i.b.resp != 2'b00) begin
            state_next     = RESP;
            rsp_valid_next = 1'b1;
            rsp_data_next  = '0;
            rsp_err_next   = ERR_BUS;
          end else if (state_reg == WR_MSG) begin
            state_next    = WR_DB;
            aw_valid_next = 1'b1;
            w_valid_next  = 1'b1;
            aw_addr_next  = DB_ADDR;
            w_data_next   = 32'h1;
          end else begin
            state_next = WAIT_CMPL;
            timer_next = '0;
          end
        end
      end

      WAIT_CMPL: begin
        // The pulse is checked first so it wins over the final timer cycle.
        if (completion_irq_i) begin
          state_next    = RD_RSP;
          ar_valid_next = 1'b1;
        end else if (timer_reg == TIMER_LAST) begin
          state_next     = RESP;
          rsp_valid_next = 1'b1;
          rsp_data_next  = '0;
          rsp_err_next   = ERR_TIMEOUT;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      RD_RSP: begin
        if (ar_hs) ar_valid_next = 1'b0;
        if (!r_ready_reg) begin
          r_ready_next = !ar_valid_reg || ar_hs;
        end else if (axi_lite_mbox_rsp_i.r_valid) begin
          r_ready_next   = 1'b0;
          state_next     = RESP;
          rsp_valid_next = 1'b1;
          if (axi_lite_mbox_rsp_i.r.resp != 2'b00) begin
            rsp_data_next = '0;
            rsp_err_next  = ERR_BUS;
          end else begin
            rsp_data_next = axi_lite_mbox_rsp_i.r.data;
            rsp_err_next  = ERR_OK;
          end
        end
      end

      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign req_ready_o = (state_reg == IDLE);
  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_data_o  = rsp_data_reg;
  assign rsp_err_o   = rsp_err_reg;

  always_comb begin
    axi_lite_mbox_req_o          = '0;
    axi_lite_mbox_req_o.aw.addr  = aw_addr_reg;
    axi_lite_mbox_req_o.aw.prot  = 3'b000;
    axi_lite_mbox_req_o.aw_valid = aw_valid_reg;
    axi_lite_mbox_req_o.w.data   = w_data_reg;
    axi_lite_mbox_req_o.w.strb   = 4'hF;
    axi_lite_mbox_req_o.w_valid  = w_valid_reg;
    axi_lite_mbox_req_o.b_ready  = b_ready_reg;
    axi_lite_mbox_req_o.ar.addr  = MSG_ADDR;
    axi_lite_mbox_req_o.ar.prot  = 3'b000;
    axi_lite_mbox_req_o.ar_valid = ar_valid_reg;
    axi_lite_mbox_req_o.r_ready  = r_ready_reg;
  end

endmodule

// File: tb/tb_scmi_mbox_doorbell_master.sv
// Bench for scmi_mbox_doorbell_master: AXI-Lite slave/mailbox model plus a transaction-level
// reference model; directed corner cases followed by randomized transactions.

module tb_scmi_mbox_doorbell_master;
  import scmi_mbox_doorbell_master_pkg::*;

  localparam int          TO    = 8;
  localparam logic [63:0] BASE  = 64'h0000_0000_4000_1000;
  localparam logic [63:0] MSG_A = BASE + 64'h20;
  localparam logic [63:0] DB_A  = BASE + 64'h24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [31:0]    req_msg = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [31:0]    rsp_data;
  logic [1:0]     rsp_err;
  logic           irq_slave = 1'b0;
  logic           irq_manual = 1'b0;
  logic           irq;
  axi_lite_req_t  mreq;
  axi_lite_resp_t sresp = '0;

  assign irq = irq_slave | irq_manual;

  scmi_mbox_doorbell_master #(
    .AXI_ADDR_WIDTH (64),
    .MBOX_BASE      (BASE),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .req_valid_i         (req_valid),
    .req_ready_o         (req_ready),
    .req_msg_i           (req_msg),
    .rsp_valid_o         (rsp_valid),
    .rsp_ready_i         (rsp_ready),
    .rsp_data_o          (rsp_data),
    .rsp_err_o           (rsp_err),
    .completion_irq_i    (irq),
    .axi_lite_mbox_req_o (mreq),
    .axi_lite_mbox_rsp_i (sresp)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave configuration and observation logs
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, irq_dly = 0;
  logic [1:0]  bresp_cfg [2];
  logic [1:0]  rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;
  logic [63:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [63:0] rd_addr_q [$];
  int          b_cnt = 0, ar_cnt = 0, viol = 0;
  int          db_b_edge = -1;

  int aw_wait = 0, w_wait = 0, ar_wait = 0, irq_cd = 0;
  bit aw_got, w_got, ar_got, b_hs, r_hs;
  bit aw_pend, w_pend, ar_pend, aw_after, w_after;

  // Slave decisions are made on the falling edge; a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      sresp = '0; irq_slave = 1'b0; irq_cd = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0;
      aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0;
      aw_pend = 0; w_pend = 0; ar_pend = 0; aw_after = 0; w_after = 0;
    end else begin
      irq_slave = 1'b0;
      if (irq_cd > 0) begin
        irq_cd--;
        if (irq_cd == 0) irq_slave = 1'b1;
      end
      if (aw_pend && !mreq.aw_valid) viol++;
      if (w_pend && !mreq.w_valid) viol++;
      if (ar_pend && !mreq.ar_valid) viol++;
      if (aw_after && mreq.aw_valid) viol++;
      if (w_after && mreq.w_valid) viol++;
      if (mreq.b_ready && (mreq.aw_valid || mreq.w_valid)) viol++;
      if (mreq.r_ready && mreq.ar_valid) viol++;
      if (b_hs) begin sresp.b_valid = 1'b0; b_hs = 0; end
      if (r_hs) begin sresp.r_valid = 1'b0; r_hs = 0; end
      sresp.aw_ready = 1'b0; sresp.w_ready = 1'b0; sresp.ar_ready = 1'b0;
      if (aw_got && w_got && !sresp.b_valid) begin
        sresp.b_valid = 1'b1;
        sresp.b.resp  = bresp_cfg[(b_cnt > 0) ? 1 : 0];
        aw_got = 0; w_got = 0;
      end
      if (ar_got && !sresp.r_valid) begin
        sresp.r_valid = 1'b1;
        sresp.r.data  = rdata_cfg;
        sresp.r.resp  = rresp_cfg;
        ar_got = 0;
      end
      if (sresp.b_valid && mreq.b_ready) begin
        b_hs = 1; b_cnt++; aw_after = 0; w_after = 0;
        if (wr_addr_q.size() > 0 && wr_addr_q[wr_addr_q.size()-1] == DB_A && sresp.b.resp == 2'b00) begin
          db_b_edge = cyc + 1;
          if (irq_dly > 0) irq_cd = irq_dly;
        end
      end
      if (sresp.r_valid && mreq.r_ready) r_hs = 1;
      if (mreq.aw_valid && !aw_got && !aw_after) begin
        if (aw_wait >= aw_dly) begin
          sresp.aw_ready = 1'b1; aw_got = 1; aw_wait = 0; aw_after = 1;
          wr_addr_q.push_back(mreq.aw.addr);
          if (mreq.aw.prot != 3'b000) viol++;
        end else aw_wait++;
      end
      if (mreq.w_valid && !w_got && !w_after) begin
        if (w_wait >= w_dly) begin
          sresp.w_ready = 1'b1; w_got = 1; w_wait = 0; w_after = 1;
          wr_data_q.push_back(mreq.w.data);
          if (mreq.w.strb != 4'hF) viol++;
        end else w_wait++;
      end
      if (mreq.ar_valid && !ar_got && !sresp.r_valid) begin
        if (ar_wait >= ar_dly) begin
          sresp.ar_ready = 1'b1; ar_got = 1; ar_wait = 0; ar_cnt++;
          rd_addr_q.push_back(mreq.ar.addr);
        end else ar_wait++;
      end
      aw_pend = mreq.aw_valid && !sresp.aw_ready;
      w_pend  = mreq.w_valid && !sresp.w_ready;
      ar_pend = mreq.ar_valid && !sresp.ar_ready;
    end
  end

  // Transaction-level expectation: status, data, bus traffic and doorbell-to-response latency.
  typedef struct {
    logic [1:0]  err;
    logic [31:0] data;
    int          n_wr;
    int          n_rd;
    int          lat;
  } exp_t;

  function automatic exp_t model(logic [1:0] b0, logic [1:0] b1, logic [1:0] rr,
                                 logic [31:0] rd, int irq_d, int ar_d);
    exp_t e;
    if (b0 != 2'b00)                  e = '{2'd1, 32'h0, 1, 0, -1};
    else if (b1 != 2'b00)             e = '{2'd1, 32'h0, 2, 0, -1};
    else if (irq_d == 0 || irq_d > TO) e = '{2'd2, 32'h0, 2, 0, TO};
    else if (rr != 2'b00)             e = '{2'd1, 32'h0, 2, 1, irq_d + 2 + ar_d};
    else                              e = '{2'd0, rd, 2, 1, irq_d + 2 + ar_d};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input string tag, input logic [31:0] msg, input int awd, input int wd,
                         input int ard, input int irqd, input logic [1:0] b0, input logic [1:0] b1,
                         input logic [1:0] rr, input logic [31:0] rd, input int hold);
    exp_t e;
    int   n;
    int   lat;
    aw_dly = awd; w_dly = wd; ar_dly = ard; irq_dly = irqd;
    bresp_cfg[0] = b0; bresp_cfg[1] = b1; rresp_cfg = rr; rdata_cfg = rd;
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    b_cnt = 0; ar_cnt = 0; db_b_edge = -1;
    e = model(b0, b1, rr, rd, irqd, ard);

    chk({tag, ":req_ready"}, req_ready, 1'b1);
    req_valid = 1'b1; req_msg = msg;
    step;
    req_valid = 1'b0;
    chk({tag, ":aw_w_valid"}, {mreq.aw_valid, mreq.w_valid, req_ready}, 3'b110);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin step; n++; end
    chk({tag, ":rsp_valid"}, rsp_valid, 1'b1);
    lat = cyc - db_b_edge;
    chk({tag, ":rsp_err"}, rsp_err, e.err);
    chk({tag, ":rsp_data"}, rsp_data, e.data);
    chk({tag, ":n_wr"}, wr_addr_q.size(), e.n_wr);
    chk({tag, ":n_wdata"}, wr_data_q.size(), e.n_wr);
    for (int i = 0; i < e.n_wr && i < wr_addr_q.size() && i < wr_data_q.size(); i++) begin
      chk({tag, ":wr_addr"}, wr_addr_q[i], (i == 0) ? MSG_A : DB_A);
      chk({tag, ":wr_data"}, wr_data_q[i], (i == 0) ? msg : 32'h1);
    end
    chk({tag, ":b_cnt"}, b_cnt, e.n_wr);
    chk({tag, ":ar_cnt"}, ar_cnt, e.n_rd);
    if (e.n_rd > 0 && rd_addr_q.size() > 0) chk({tag, ":ar_addr"}, rd_addr_q[0], MSG_A);
    if (e.lat >= 0) chk({tag, ":latency"}, lat, e.lat);
    chk({tag, ":protocol"}, viol, 0);
    for (int i = 0; i < hold; i++) begin
      step;
      chk({tag, ":hold"}, {rsp_valid, req_ready, rsp_err, rsp_data}, {1'b1, 1'b0, e.err, e.data});
    end
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    chk({tag, ":after_rsp"}, {rsp_valid, req_ready}, 2'b01);
    $display("txn %s msg=%08h err=%0d data=%08h wr=%0d rd=%0d lat=%0d", tag, msg, rsp_err, rsp_data,
             wr_addr_q.size(), ar_cnt, lat);
  endtask

  initial begin
    bresp_cfg[0] = 2'b00;
    bresp_cfg[1] = 2'b00;
    repeat (3) step;
    chk("reset:req_ready", req_ready, 1'b1);
    chk("reset:axi", {mreq.aw_valid, mreq.w_valid, mreq.b_ready, mreq.ar_valid, mreq.r_ready}, 5'b0);
    chk("reset:rsp", {rsp_valid, rsp_err, rsp_data}, 35'b0);
    rst = 1'b0;
    step;
    chk("post_reset:req_ready", req_ready, 1'b1);

    run_txn("nominal",   32'hCAFE0001, 0, 0, 0, 5, 2'b00, 2'b00, 2'b00, 32'h0000_0042, 0);
    run_txn("aw_w_skew", 32'h1234_5678, 3, 0, 0, 3, 2'b00, 2'b00, 2'b00, 32'hA5A5_0001, 0);
    run_txn("timeout",   32'h0BAD_0001, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 32'hDEAD_BEEF, 0);
    run_txn("irq_last",  32'h0000_0008, 0, 0, 0, TO, 2'b00, 2'b00, 2'b00, 32'h1111_2222, 0);
    run_txn("irq_late",  32'h0000_0009, 0, 0, 0, TO + 1, 2'b00, 2'b00, 2'b00, 32'h3333_4444, 0);
    run_txn("db_slverr", 32'h5555_0001, 0, 0, 0, 3, 2'b00, 2'b10, 2'b00, 32'h7777_7777, 0);
    run_txn("msg_slverr", 32'h5555_0002, 0, 0, 0, 3, 2'b10, 2'b00, 2'b00, 32'h7777_7777, 0);
    run_txn("rd_decerr", 32'h6666_0001, 0, 0, 1, 2, 2'b00, 2'b00, 2'b11, 32'h9999_9999, 0);
    run_txn("backpress", 32'h7777_0001, 0, 1, 0, 4, 2'b00, 2'b00, 2'b00, 32'hFEED_F00D, 10);

    // Reset while waiting for completion, then a stale pulse
    aw_dly = 0; w_dly = 0; ar_dly = 0; irq_dly = 0;
    bresp_cfg[0] = 2'b00; bresp_cfg[1] = 2'b00;
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    b_cnt = 0; ar_cnt = 0; db_b_edge = -1;
    req_valid = 1'b1; req_msg = 32'h0F0F_0F0F;
    step;
    req_valid = 1'b0;
    for (int i = 0; i < 50 && db_b_edge < 0; i++) step;
    chk("rst_wait:reached", db_b_edge >= 0, 1'b1);
    step; step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("rst_wait:idle", {req_ready, rsp_valid}, 2'b10);
    chk("rst_wait:valids", {mreq.aw_valid, mreq.w_valid, mreq.b_ready, mreq.ar_valid, mreq.r_ready}, 5'b0);
    irq_manual = 1'b1;
    step;
    irq_manual = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step;
      chk("stale_irq:quiet", {req_ready, rsp_valid, mreq.aw_valid, mreq.w_valid, mreq.ar_valid}, 5'b10000);
    end
    chk("stale_irq:no_ar", ar_cnt, 0);
    $display("txn reset_in_wait msg=0f0f0f0f ar=%0d", ar_cnt);
    run_txn("recover", 32'hC0DE_0001, 0, 0, 0, 2, 2'b00, 2'b00, 2'b00, 32'h0000_0077, 1);

    for (int t = 0; t < 30; t++) begin
      logic [1:0] b0, b1, rr;
      b0 = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b00;
      b1 = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b00;
      rr = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_txn($sformatf("rand%0d", t), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 11), b0, b1, rr, $urandom,
              $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
